// File: rtl/obi_slave_be.sv
// rtl/obi_slave_be.sv - OBI slave word memory with byte enables and a single outstanding response.
// Optional macro OBI_SLAVE_BE_RANGE_CHK_EN: addresses at or beyond MEM_DEPTH report an error instead of wrapping.
module obi_slave_be #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int AUSER_WIDTH = 0,
    parameter int WUSER_WIDTH = 0,
    parameter int RUSER_WIDTH = 0,
    parameter int ID_WIDTH    = 0,
    parameter int ACHK_WIDTH  = 0,
    parameter int RCHK_WIDTH  = 0,
    parameter int COMB_GNT    = 0,
    parameter int MEM_DEPTH   = 256
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADCAB1E);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RESP = 2'b01
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    ready;
    logic                    accept;
    logic                    addr_ok;
    logic [IDX_W-1:0]        idx;

    // The optional-signal widths are reserved; they only need to be non-negative.
    generate
        if (AUSER_WIDTH < 0 || WUSER_WIDTH < 0 || RUSER_WIDTH < 0 ||
            ID_WIDTH < 0 || ACHK_WIDTH < 0 || RCHK_WIDTH < 0) begin : g_rsvd_width_invalid
        end
    endgenerate

    assign ready        = (state == IDLE) || (state == RESP && obi_rready_i);
    assign obi_gnt_o    = (COMB_GNT != 0) ? (obi_req_i && ready) : ready;
    assign accept       = obi_req_i && obi_gnt_o;
    assign obi_rvalid_o = (state == RESP);
    assign idx          = obi_addr_i[IDX_W-1:0];

`ifdef OBI_SLAVE_BE_RANGE_CHK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    assign addr_ok = ({1'b0, obi_addr_i} < DEPTH_EXT);
`else
    // Without range checking the upper address bits are ignored: the index wraps.
    logic unused_addr;
    assign unused_addr = ^obi_addr_i;
    assign addr_ok     = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (accept && obi_we_i && addr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (obi_be_i[b]) begin
                    mem[idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // A new acceptance always wins over plain completion, giving one transfer per cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            obi_rdata_o <= '0;
            obi_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                state     <= RESP;
                obi_err_o <= !addr_ok;
                if (!addr_ok) begin
                    obi_rdata_o <= ERR_DATA;
                end else if (!obi_we_i) begin
                    obi_rdata_o <= mem[idx];
                end
            end else if (state == RESP && obi_rready_i) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_obi_slave_be.sv
// tb/tb_obi_slave_be.sv - Randomized and directed bench for obi_slave_be against a transaction-level model.
module tb_obi_slave_be;

    localparam int DEPTH = 256;

    logic        clk_i    = 1'b0;
    logic        reset_ni = 1'b0;
    logic        req      = 1'b0;
    logic        we       = 1'b0;
    logic        rready   = 1'b0;
    logic [31:0] addr     = '0;
    logic [31:0] wdata    = '0;
    logic [3:0]  be       = '0;

    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic        gnt_c, rvalid_c, err_c;
    logic [31:0] rdata_c;

    obi_slave_be #(.COMB_GNT(0)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .obi_req_i(req), .obi_gnt_o(gnt),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
        .obi_rvalid_o(rvalid), .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err)
    );

    obi_slave_be #(.COMB_GNT(1)) dut_c (
        .clk_i(clk_i), .reset_ni(reset_ni), .obi_req_i(req), .obi_gnt_o(gnt_c),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
        .obi_rvalid_o(rvalid_c), .obi_rready_i(rready), .obi_rdata_o(rdata_c), .obi_err_o(err_c)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mem [DEPTH];
    bit          m_loaded = 1'b0;
    bit          m_valid;
    logic [31:0] m_rdata;
    bit          m_err;

    function automatic logic [31:0] preload(input int i);
        logic [31:0] v;
        v = (32'(i) * 32'h9E3779B1) ^ 32'hC3A50F1E;
        return (i == 4) ? 32'hDA7A5EAD : v;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef OBI_SLAVE_BE_RANGE_CHK_EN
        return a < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a % DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending response; a new request is taken whenever none is pending
    // or the pending one retires in the same cycle.
    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            m_valid <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
            if (!m_loaded) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= preload(i);
                m_loaded <= 1'b1;
            end
        end else if (req && (!m_valid || rready)) begin
            m_valid <= 1'b1;
            if (!in_range(addr)) begin
                m_err   <= 1'b1;
                m_rdata <= 32'hBADCAB1E;
            end else begin
                m_err <= 1'b0;
                if (we) m_mem[widx(addr)] <= merge(m_mem[widx(addr)], wdata, be);
                else    m_rdata <= m_mem[widx(addr)];
            end
        end else if (m_valid && rready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("rvalid", rvalid, m_valid);
            chk("rdata", rdata, m_rdata);
            chk("err", err, m_err);
            chk("gnt", gnt, (!m_valid || rready));
            chk("rvalid_c", rvalid_c, m_valid);
            chk("rdata_c", rdata_c, m_rdata);
            chk("err_c", err_c, m_err);
            chk("gnt_c", gnt_c, req && (!m_valid || rready));
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit rr);
        @(negedge clk_i);
        #2;
        req = r; we = w; addr = a; wdata = d; be = b; rready = rr;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem[i]   = preload(i);
            dut_c.mem[i] = preload(i);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #2 reset_ni = 1'b1;
        #1;
        chk("rst_state", 32'(dut.state), 32'h0);
        chk("rst_rvalid", rvalid, 32'h0);
        chk("rst_gnt", gnt, 32'h1);
        chk("rst_gnt_c", gnt_c, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", err, 32'h0);
        chk_en = 1'b1;

        cyc(1, 0, 32'h4, 32'h0, 4'h0, 1);
        chk("rd4_rvalid", rvalid, 32'h1);
        chk("rd4_rdata", rdata, 32'hDA7A5EAD);
        chk("rd4_err", err, 32'h0);
        chk("model_rd4", m_rdata, 32'hDA7A5EAD);

        cyc(1, 1, 32'h2, 32'h1337C0DE, 4'hF, 1);
        chk("wr_full_rvalid", rvalid, 32'h1);
        chk("wr_keeps_rdata", rdata, 32'hDA7A5EAD);
        chk("wr_full_mem", dut.mem[2], 32'h1337C0DE);
        cyc(1, 1, 32'h2, 32'hFFFFFFFF, 4'b0011, 1);
        chk("wr_part_mem", dut.mem[2], 32'h1337FFFF);
        chk("model_wr_part", m_mem[2], 32'h1337FFFF);
        cyc(1, 1, 32'h2, 32'h00000000, 4'h0, 1);
        chk("wr_be0_mem", dut.mem[2], 32'h1337FFFF);
        chk("wr_be0_rvalid", rvalid, 32'h1);
        chk("wr_be0_err", err, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 4'h0, 1);
        chk("idle_rvalid", rvalid, 32'h0);

        cyc(1, 0, 32'h4, 32'h0, 4'h0, 0);
        chk("stall_start", rvalid, 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 32'h2, 32'h0, 4'h0, 0);
            chk("stall_gnt", gnt, 32'h0);
            chk("stall_gnt_c", gnt_c, 32'h0);
            chk("stall_rvalid", rvalid, 32'h1);
            chk("stall_rdata", rdata, 32'hDA7A5EAD);
        end
        cyc(0, 0, 32'h0, 32'h0, 4'h0, 1);
        chk("stall_done_rvalid", rvalid, 32'h0);
        chk("stall_done_state", 32'(dut.state), 32'h0);

        cyc(1, 0, 32'h4, 32'h0, 4'h0, 1);
        chk("b2b_first", rdata, 32'hDA7A5EAD);
        cyc(1, 0, 32'h2, 32'h0, 4'h0, 1);
        chk("b2b_rvalid", rvalid, 32'h1);
        chk("b2b_second", rdata, 32'h1337FFFF);
        cyc(0, 0, 32'h0, 32'h0, 4'h0, 1);
        chk("b2b_end", rvalid, 32'h0);

`ifdef OBI_SLAVE_BE_RANGE_CHK_EN
        cyc(1, 0, 32'hFFFFFFFF, 32'h0, 4'h0, 1);
        chk("oor_rd_err", err, 32'h1);
        chk("oor_rd_rdata", rdata, 32'hBADCAB1E);
        cyc(1, 1, 32'hFFFFFFFF, 32'h0, 4'hF, 1);
        chk("oor_wr_err", err, 32'h1);
        chk("oor_wr_mem", dut.mem[255], preload(255));
`else
        cyc(1, 0, 32'h104, 32'h0, 4'h0, 1);
        chk("wrap_rd_rdata", rdata, 32'hDA7A5EAD);
        chk("wrap_rd_err", err, 32'h0);
`endif
        cyc(0, 0, 32'h0, 32'h0, 4'h0, 1);

        cyc(1, 0, 32'h4, 32'h0, 4'h0, 0);
        chk("mid_rst_pre", rvalid, 32'h1);
        @(negedge clk_i);
        #2 req = 1'b0; reset_ni = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 32'h0);
        chk("mid_rst_state", 32'(dut.state), 32'h0);
        chk("mid_rst_rdata", rdata, 32'h0);
        @(negedge clk_i);
        #2 reset_ni = 1'b1;
        #1;
        chk("rst_keeps_mem", dut.mem[4], 32'hDA7A5EAD);

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, 32'($urandom),
                4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk_i);
                #2 req = 1'b0; reset_ni = 1'b0;
                @(negedge clk_i);
                #2 reset_ni = 1'b1;
            end
        end
        cyc(0, 0, 32'h0, 32'h0, 4'h0, 1);
        cyc(0, 0, 32'h0, 32'h0, 4'h0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("final_mem", dut.mem[i], m_mem[i]);
            chk("final_mem_c", dut_c.mem[i], m_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_slave_be.md
OBI_SLAVE_BE -- requirements
Module: obi_slave_be

Interface
REQ-001 The block SHALL have one clock, clk_i, and an asynchronous, active-low reset, reset_ni.
REQ-002 Parameter ADDR_WIDTH, default 32: obi_addr_i width.
REQ-003 Parameter DATA_WIDTH, default 32: data width, a multiple of 8.
REQ-004 Parameters AUSER_WIDTH, WUSER_WIDTH, RUSER_WIDTH, ID_WIDTH, ACHK_WIDTH, RCHK_WIDTH, default 0 each: reserved optional-signal widths; no ports, no function.
REQ-005 Parameter COMB_GNT, default 0: grant mode, per REQ-012.
REQ-006 Parameter MEM_DEPTH, default 256: memory depth in words.
REQ-007 Ports, one per line (name  direction  width  meaning):
- clk_i  in  1  clock
- reset_ni  in  1  async active-low reset
- obi_req_i  in  1  A-channel request
- obi_gnt_o  out  1  A-channel grant
- obi_addr_i  in  ADDR_WIDTH  word index
- obi_we_i  in  1  1 = write, 0 = read
- obi_be_i  in  DATA_WIDTH/8  byte enables
- obi_wdata_i  in  DATA_WIDTH  write data
- obi_rvalid_o  out  1  R-channel valid
- obi_rready_i  in  1  R-channel ready
- obi_rdata_o  out  DATA_WIDTH  read data
- obi_err_o  out  1  response error
REQ-008 Storage SHALL be an unpacked array named mem, with MEM_DEPTH words of DATA_WIDTH bits, loadable hierarchically (e.g. $readmemh) before traffic.
REQ-009 The FSM register SHALL be named state, 2 bits wide: IDLE=2'b00, RESP=2'b01; other codes SHALL be unreachable.

Function
REQ-010 Addressing SHALL be word-indexed: obi_addr_i selects mem[obi_addr_i] directly, with no byte-offset shift.
REQ-011 A transfer SHALL be accepted on a rising edge where obi_req_i and obi_gnt_o are both 1.
REQ-012 Grant:
- "ready" = (state==IDLE) or (state==RESP and obi_rready_i).
- COMB_GNT=0: obi_gnt_o = ready, independent of obi_req_i.
- COMB_GNT=1: obi_gnt_o = obi_req_i and ready.
REQ-013 Read, on acceptance: obi_rdata_o <= mem[addr], registered; obi_rvalid_o=1 from the next cycle.
REQ-014 Write, on acceptance: update only bytes whose obi_be_i bit is 1. obi_rvalid_o=1 next cycle with obi_err_o=0. obi_rdata_o keeps its previous value.
REQ-015 The response SHALL complete on a rising edge with obi_rvalid_o and obi_rready_i both 1.
REQ-016 While obi_rvalid_o=1 and obi_rready_i=0, obi_rvalid_o, obi_rdata_o and obi_err_o SHALL hold stable, and obi_gnt_o=0.
REQ-017 Transitions:
- IDLE->RESP on acceptance.
- RESP->RESP on completion with a new acceptance (back-to-back, one transfer per cycle).
- RESP->IDLE on completion without acceptance.
- Otherwise hold.
REQ-018 At most one outstanding transfer; obi_rvalid_o SHALL equal (state==RESP).
REQ-019 A read in the same cycle as a completing write to the same address SHALL return the updated data (writes precede reads in order).
REQ-020 obi_be_i=0 on a write SHALL leave mem unchanged and still produce a response.

Reset
REQ-021 While reset_ni=0 (asynchronous): state=IDLE, obi_rvalid_o=0, obi_err_o=0, obi_rdata_o=0.
REQ-022 After reset, obi_gnt_o=1 when COMB_GNT=0, or follows obi_req_i when COMB_GNT=1.
REQ-023 Reset SHALL NOT clear mem.
REQ-024 Reset asserted mid-transfer SHALL discard the pending response.

Configuration
REQ-025 Macro OBI_SLAVE_BE_RANGE_CHK_EN SHALL select address handling:
- Defined: obi_addr_i >= MEM_DEPTH gives obi_err_o=1 and obi_rdata_o=32'hBADCAB1E (low DATA_WIDTH bits); writes are suppressed; the handshake is unchanged.
- Undefined: the address is taken modulo MEM_DEPTH (low log2(MEM_DEPTH) bits) and obi_err_o is constant 0.

Verification
REQ-026 Pulse reset_ni low -> state==2'b00, obi_rvalid_o=0, obi_gnt_o=1 (COMB_GNT=0).
REQ-027 mem[4]=DA7A5EAD preloaded; read addr 0x4 with rready=1 -> next cycle rvalid=1, rdata=DA7A5EAD, err=0.
REQ-028 Write 0x1337C0DE to addr 0x2 with be=4'hF -> mem[2]==1337C0DE; be=4'b0011 with 0xFFFFFFFF -> mem[2]==1337FFFF.
REQ-029 Read with rready=0 for 3 cycles -> rvalid and rdata stable, gnt=0; raise rready -> completion, then back to IDLE.
REQ-030 Back-to-back reads of addr 4 then addr 2 with rready=1 -> rvalid high for two consecutive cycles with the correct data each cycle.
REQ-031 With OBI_SLAVE_BE_RANGE_CHK_EN, read addr 0xFFFFFFFF -> err=1, rdata=BADCAB1E; a write to it leaves mem unchanged.
